// File: rtl/adc_pkg.sv
// Shared types and address constants for the XADC DRP sampler.
package adc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_ACCUM = 2'd3
   } state_e;

   localparam logic [6:0] DRP_TEMP    = 7'h00;
   localparam logic [6:0] DRP_VAUX6   = 7'h16;
   localparam logic [6:0] DRP_CONFIG0 = 7'h40;

   localparam logic [31:0] ADC_AD = 32'h1100_0050;

   function automatic logic [11:0] drp_code(input logic [15:0] d);
      return d[15:4];
   endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Boxcar averager: sums 2^AVG_LOG2 samples, then registers the floored mean
// and strobes ADC_VALID for one cycle.
module adc_avg_accum #(
   parameter int AVG_LOG2 = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [11:0] sample,
   input  logic        valid,
   output logic [11:0] ADC_VALUE,
   output logic        ADC_VALID
);

   localparam int AW = 12 + AVG_LOG2;
   localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   val_q, val_d;
   logic          vld_q, vld_d;
   logic [AW-1:0] sum;

   always_comb begin
      sum   = acc_q + AW'(sample);
      acc_d = acc_q;
      cnt_d = cnt_q;
      val_d = val_q;
      vld_d = 1'b0;
      if (valid) begin
         if (cnt_q == CNT_LAST) begin
            val_d = 12'(sum >> AVG_LOG2);
            vld_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q <= '0;
         cnt_q <= '0;
         val_q <= '0;
         vld_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         val_q <= val_d;
         vld_q <= vld_d;
      end
   end

   assign ADC_VALUE = val_q;
   assign ADC_VALID = vld_q;

endmodule

// File: rtl/adc_drp_sampler.sv
// XADC DRP reader: one channel read per end-of-conversion, with a DRDY
// timeout, a 1-deep pending request, and a boxcar-averaged output.
module adc_drp_sampler
   import adc_pkg::*;
#(
   parameter logic [6:0] CHANNEL_ADDR = DRP_VAUX6,
   parameter int         AVG_LOG2     = 4,
   parameter int         TIMEOUT      = 63
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EOC,
   input  logic        DRDY,
   input  logic [15:0] DO,
   output logic        DEN,
   output logic        DWE,
   output logic [6:0]  DADDR,
   output logic [11:0] ADC_VALUE,
   output logic        ADC_VALID,
   output logic        ADC_ERR
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   logic          pend_q, pend_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [11:0]   smp_q, smp_d;
   logic          err_q, err_d;
   logic          den;
   logic          acc_vld;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      tmo_d   = tmo_q;
      smp_d   = smp_q;
      err_d   = err_q;
      den     = 1'b0;
      acc_vld = 1'b0;
      // any EOC seen outside IDLE (including the cycle we return) is kept
      if (EOC && (state_q != S_IDLE)) pend_d = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (EOC || pend_q) begin
               state_d = S_REQ;
               pend_d  = 1'b0;
            end
         end
         S_REQ: begin
            den     = 1'b1;
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (DRDY) begin
               smp_d   = drp_code(DO);
               state_d = S_ACCUM;
            end else if (tmo_q == TW'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_ACCUM: begin
            acc_vld = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         pend_q  <= 1'b0;
         tmo_q   <= '0;
         smp_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         tmo_q   <= tmo_d;
         smp_q   <= smp_d;
         err_q   <= err_d;
      end
   end

   adc_avg_accum #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .CLK       (CLK),
      .RST       (RST),
      .sample    (smp_q),
      .valid     (acc_vld),
      .ADC_VALUE (ADC_VALUE),
      .ADC_VALID (ADC_VALID)
   );

   assign DEN     = den;
   assign DWE     = 1'b0;
   assign DADDR   = CHANNEL_ADDR;
   assign ADC_ERR = err_q;

endmodule

// File: tb/tb_adc_drp_sampler.sv
// Bench for adc_drp_sampler: three averaging depths driven in parallel.
module tb_adc_drp_sampler;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        EOC = 1'b0;
   logic        DRDY = 1'b0;
   logic [15:0] DO = 16'h0;

   logic        den [3];
   logic        dwe [3];
   logic [6:0]  daddr [3];
   logic [11:0] val [3];
   logic        vld [3];
   logic        err [3];
   logic [2:0]  vlds, errs;

   assign vlds = {vld[2], vld[1], vld[0]};
   assign errs = {err[2], err[1], err[0]};

   always #5 CLK = ~CLK;

   adc_drp_sampler #(.AVG_LOG2(0)) u0 (
      .CLK(CLK), .RST(RST), .EOC(EOC), .DRDY(DRDY), .DO(DO),
      .DEN(den[0]), .DWE(dwe[0]), .DADDR(daddr[0]),
      .ADC_VALUE(val[0]), .ADC_VALID(vld[0]), .ADC_ERR(err[0]));
   adc_drp_sampler #(.AVG_LOG2(2)) u2 (
      .CLK(CLK), .RST(RST), .EOC(EOC), .DRDY(DRDY), .DO(DO),
      .DEN(den[1]), .DWE(dwe[1]), .DADDR(daddr[1]),
      .ADC_VALUE(val[1]), .ADC_VALID(vld[1]), .ADC_ERR(err[1]));
   adc_drp_sampler #(.AVG_LOG2(4)) u4 (
      .CLK(CLK), .RST(RST), .EOC(EOC), .DRDY(DRDY), .DO(DO),
      .DEN(den[2]), .DWE(dwe[2]), .DADDR(daddr[2]),
      .ADC_VALUE(val[2]), .ADC_VALID(vld[2]), .ADC_ERR(err[2]));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] code;
      int          dly;
      logic [2:0]  v;
      logic [11:0] e0, e2, e4;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; EOC = 1'b0; DRDY = 1'b0; DO = '0;
      repeat (2) tick();
      RST = 1'b0;
      tick();
   endtask

   // EOC at cycle 0, DEN expected at 1, DRDY at 1+dly, result at 3+dly
   task automatic convert(input logic [11:0] code, input int dly,
                          output logic [2:0] v,
                          output logic [2:0][11:0] xv);
      logic den_bad;
      den_bad = 1'b0;
      DRDY = 1'b0;
      EOC = 1'b1;
      tick();
      EOC = 1'b0;
      chk("den_on", den[0], 1);
      tick();
      chk("den_off", den[0], 0);
      for (int i = 1; i < dly; i++) begin
         tick();
         if (den[0]) den_bad = 1'b1;
      end
      DRDY = 1'b1;
      DO = {code, 4'h0};
      tick();
      DRDY = 1'b0;
      DO = 16'($urandom);
      chk("vld_early", vlds, 0);
      tick();
      v = vlds;
      xv[0] = val[0]; xv[1] = val[1]; xv[2] = val[2];
      tick();
      chk("vld_pulse", vlds, 0);
      chk("den_wait", den_bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]        v;
      logic [2:0][11:0]  xv;
      int                nden, first_den, dr_at, nv, anyv, extra;
      logic [11:0]       lastv;
      logic              e_early, e_late;
      int                q [3][$];
      int                held [3];
      logic [2:0]        ev;
      int                lg [3];
      int                sum;

      tbl[0]  = '{12'd100,  1, 3'b001, 12'd100, 12'd0,   12'd0};
      tbl[1]  = '{12'd101,  2, 3'b001, 12'd101, 12'd0,   12'd0};
      tbl[2]  = '{12'd102,  3, 3'b001, 12'd102, 12'd0,   12'd0};
      tbl[3]  = '{12'd104,  4, 3'b011, 12'd104, 12'd101, 12'd0};
      tbl[4]  = '{12'hFFF,  5, 3'b001, 12'hFFF, 12'd101, 12'd0};
      tbl[5]  = '{12'hFFF,  1, 3'b001, 12'hFFF, 12'd101, 12'd0};
      tbl[6]  = '{12'hFFF, 20, 3'b001, 12'hFFF, 12'd101, 12'd0};
      tbl[7]  = '{12'hFFF,  2, 3'b011, 12'hFFF, 12'hFFF, 12'd0};
      tbl[8]  = '{12'hABC,  3, 3'b001, 12'hABC, 12'hFFF, 12'd0};
      tbl[9]  = '{12'hABC,  1, 3'b001, 12'hABC, 12'hFFF, 12'd0};
      tbl[10] = '{12'hABC, 64, 3'b001, 12'hABC, 12'hFFF, 12'd0};
      tbl[11] = '{12'hABC,  2, 3'b011, 12'hABC, 12'hABC, 12'd0};
      tbl[12] = '{12'hABC,  7, 3'b001, 12'hABC, 12'hABC, 12'd0};
      tbl[13] = '{12'hABC,  1, 3'b001, 12'hABC, 12'hABC, 12'd0};
      tbl[14] = '{12'hABC,  9, 3'b001, 12'hABC, 12'hABC, 12'd0};
      tbl[15] = '{12'hABC,  3, 3'b111, 12'hABC, 12'hABC, 12'h977};

      do_reset();
      chk("rst_val0", val[0], 0);
      chk("rst_val2", val[1], 0);
      chk("rst_val4", val[2], 0);
      chk("rst_vld", vlds, 0);
      chk("rst_err", errs, 0);
      chk("rst_den", den[0], 0);
      chk("dwe", {dwe[2], dwe[1], dwe[0]}, 0);
      chk("daddr", daddr[0], 7'h16);

      convert(12'hABC, 3, v, xv);
      chk("abc_v0", v[0], 1);
      chk("abc_val0", xv[0], 12'hABC);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         convert(tbl[i].code, tbl[i].dly, v, xv);
         chk($sformatf("tbl%0d_v", i), v, tbl[i].v);
         chk($sformatf("tbl%0d_x0", i), xv[0], tbl[i].e0);
         chk($sformatf("tbl%0d_x2", i), xv[1], tbl[i].e2);
         chk($sformatf("tbl%0d_x4", i), xv[2], tbl[i].e4);
      end

      // two EOCs during WAIT: one pending read, one dropped
      nden = 0; first_den = 0; dr_at = -1; nv = 0; lastv = '0;
      EOC = 1'b1;
      tick();
      EOC = 1'b0;
      chk("pend_den0", den[0], 1);
      for (int cyc = 2; cyc <= 40; cyc++) begin
         tick();
         EOC = (cyc == 3) || (cyc == 4);
         DRDY = (cyc == 6) || (cyc == dr_at);
         DO = (cyc == 6) ? 16'h1230 : 16'h4560;
         if (den[0]) begin
            nden++;
            if (first_den == 0) first_den = cyc;
            dr_at = cyc + 2;
         end
         if (vld[0]) begin
            nv++;
            lastv = val[0];
         end
      end
      EOC = 1'b0;
      DRDY = 1'b0;
      chk("pend_nden", nden, 1);
      chk("pend_dencyc", first_den, 9);
      chk("pend_nv", nv, 2);
      chk("pend_last", lastv, 12'h456);
      chk("pend_err", errs, 0);

      // spurious DRDY while IDLE
      DRDY = 1'b1;
      DO = 16'hFFF0;
      tick();
      DRDY = 1'b0;
      anyv = 0; extra = 0;
      repeat (5) begin
         tick();
         if (vlds != 0) anyv = 1;
         if (den[0]) extra = 1;
      end
      chk("spur_vld", anyv, 0);
      chk("spur_den", extra, 0);
      chk("spur_val0", val[0], 12'h456);
      chk("spur_val2", val[1], 12'hABC);
      chk("spur_val4", val[2], 12'h977);
      convert(12'h200, 2, v, xv);
      chk("spur_v_a", v, 3'b001);
      convert(12'h300, 2, v, xv);
      chk("spur_v_b", v, 3'b011);
      chk("spur_avg2", xv[1], 12'h29E);

      // async reset during WAIT after 2 of 4 samples
      do_reset();
      convert(12'd4000, 2, v, xv);
      convert(12'd4000, 2, v, xv);
      EOC = 1'b1;
      tick();
      EOC = 1'b0;
      tick();
      #3;
      RST = 1'b1;
      #1;
      chk("mrst_val0", val[0], 0);
      chk("mrst_vals", {val[2], val[1]}, 0);
      chk("mrst_den", den[0], 0);
      chk("mrst_vld", vlds, 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      tick();
      convert(12'd10, 1, v, xv);
      chk("mrst_v1", v, 3'b001);
      convert(12'd20, 2, v, xv);
      chk("mrst_v2", v, 3'b001);
      convert(12'd30, 3, v, xv);
      chk("mrst_v3", v, 3'b001);
      convert(12'd41, 4, v, xv);
      chk("mrst_v4", v, 3'b011);
      chk("mrst_avg", xv[1], 12'd25);
      chk("mrst_x0", xv[0], 12'd41);

      // DRDY never comes
      anyv = 0; extra = 0;
      EOC = 1'b1;
      tick();
      EOC = 1'b0;
      chk("tmo_den", den[0], 1);
      e_early = 1'b1; e_late = 1'b0;
      for (int cyc = 2; cyc <= 75; cyc++) begin
         tick();
         if (vlds != 0) anyv = 1;
         if (den[0]) extra = 1;
         if (cyc == 62) e_early = err[0];
         if (cyc == 67) e_late = err[0];
      end
      chk("tmo_early", e_early, 0);
      chk("tmo_late", e_late, 1);
      chk("tmo_vld", anyv, 0);
      chk("tmo_extra_den", extra, 0);
      chk("tmo_errs", errs, 3'b111);
      convert(12'h5A5, 4, v, xv);
      chk("tmo_next_v0", v[0], 1);
      chk("tmo_next_x0", xv[0], 12'h5A5);
      chk("tmo_sticky", errs, 3'b111);

      // randomized conversions against a queue-based averaging model
      do_reset();
      chk("rnd_rst_err", errs, 0);
      lg[0] = 0; lg[1] = 2; lg[2] = 4;
      for (int j = 0; j < 3; j++) held[j] = 0;
      for (int n = 0; n < 48; n++) begin
         logic [11:0] code;
         int          gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            DRDY = ($urandom_range(0, 3) == 0);
            DO = 16'($urandom);
            tick();
         end
         DRDY = 1'b0;
         code = 12'($urandom_range(0, 4095));
         convert(code, $urandom_range(1, 30), v, xv);
         for (int j = 0; j < 3; j++) begin
            q[j].push_back(code);
            ev[j] = 1'b0;
            if (q[j].size() == (1 << lg[j])) begin
               sum = 0;
               foreach (q[j][k]) sum += q[j][k];
               held[j] = sum >> lg[j];
               ev[j] = 1'b1;
               q[j].delete();
            end
         end
         chk($sformatf("rnd%0d_v", n), v, ev);
         for (int j = 0; j < 3; j++)
            chk($sformatf("rnd%0d_x%0d", n, j), xv[j], held[j]);
      end
      chk("rnd_err", errs, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
